// File: rtl/regfile_sb.sv
// Register bank: 2 read ports, 1 write port, optional bypass and hardwired zero register,
// plus a pending-write scoreboard that tracks outstanding producers for RAW/WAW hazards.
module regfile_sb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int SYNC_READ = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rReg1,
    input  logic [ADDR_W-1:0] rReg2,
    output logic [DATA_W-1:0] rData1,
    output logic [DATA_W-1:0] rData2,
    output logic              rBusy1,
    output logic              rBusy2,
    input  logic [ADDR_W-1:0] wRegAddrs,
    input  logic [DATA_W-1:0] wData,
    input  logic              RegWrite,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_stall,
    output logic [ADDR_W:0]   pending_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pending;
    logic [ADDR_W:0]   r_count;

    logic              w_zero1, w_zero2, w_zero_w, w_zero_i;
    logic              w_hit1, w_hit2;
    logic [DATA_W-1:0] w_rd1, w_rd2;
    logic              w_busy1, w_busy2;
    logic              w_accept, w_inc, w_dec;

    assign w_zero1  = (ZERO_REG != 0) && (rReg1 == '0);
    assign w_zero2  = (ZERO_REG != 0) && (rReg2 == '0);
    assign w_zero_w = (ZERO_REG != 0) && (wRegAddrs == '0);
    assign w_zero_i = (ZERO_REG != 0) && (issue_addr == '0);

    assign w_hit1 = (BYPASS != 0) && RegWrite && (wRegAddrs == rReg1) && !w_zero1;
    assign w_hit2 = (BYPASS != 0) && RegWrite && (wRegAddrs == rReg2) && !w_zero2;

    always_comb begin
        w_rd1 = r_regs[rReg1];
        w_rd2 = r_regs[rReg2];
        if (w_hit1)  w_rd1 = wData;
        if (w_hit2)  w_rd2 = wData;
        if (w_zero1) w_rd1 = '0;
        if (w_zero2) w_rd2 = '0;
    end

    assign w_busy1 = r_pending[rReg1] && !w_hit1 && !w_zero1;
    assign w_busy2 = r_pending[rReg2] && !w_hit2 && !w_zero2;

    assign issue_stall = issue_valid && r_pending[issue_addr]
                         && !(RegWrite && (wRegAddrs == issue_addr));
    assign w_accept    = issue_valid && !issue_stall && !w_zero_i;

    // A same-address set+clear leaves the bit set, so it is neither an increment nor a decrement.
    assign w_inc = w_accept && !r_pending[issue_addr];
    assign w_dec = RegWrite && r_pending[wRegAddrs]
                   && !(w_accept && (issue_addr == wRegAddrs));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            if (RegWrite && !w_zero_w) r_regs[wRegAddrs] <= wData;
            if (RegWrite) r_pending[wRegAddrs] <= 1'b0;
            if (w_accept) r_pending[issue_addr] <= 1'b1;
            if (w_inc && !w_dec)      r_count <= r_count + 1'b1;
            else if (w_dec && !w_inc) r_count <= r_count - 1'b1;
        end
    end

    assign pending_count = r_count;

    if (SYNC_READ != 0) begin : g_sync_read
        always_ff @(posedge clock) begin
            if (reset) begin
                rData1 <= '0;
                rData2 <= '0;
                rBusy1 <= 1'b0;
                rBusy2 <= 1'b0;
            end else begin
                rData1 <= w_rd1;
                rData2 <= w_rd2;
                rBusy1 <= w_busy1;
                rBusy2 <= w_busy2;
            end
        end
    end else begin : g_comb_read
        assign rData1 = w_rd1;
        assign rData2 = w_rd2;
        assign rBusy1 = w_busy1;
        assign rBusy2 = w_busy2;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a combinational-read/bypass instance and a registered-read/no-bypass
// instance share stimulus and are compared against an array-based reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rReg1 = '0, rReg2 = '0, wRegAddrs = '0, issue_addr = '0;
    logic [31:0] wData = '0;
    logic        RegWrite = 1'b0, issue_valid = 1'b0;

    logic [31:0] c_rd1, c_rd2, s_rd1_o, s_rd2_o;
    logic        c_b1, c_b2, c_stall, s_b1_o, s_b2_o, s_stall;
    logic [5:0]  c_cnt, s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .SYNC_READ(0)) u_comb (
        .clock(clk), .reset(rst), .rReg1(rReg1), .rReg2(rReg2),
        .rData1(c_rd1), .rData2(c_rd2), .rBusy1(c_b1), .rBusy2(c_b2),
        .wRegAddrs(wRegAddrs), .wData(wData), .RegWrite(RegWrite),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .issue_stall(c_stall), .pending_count(c_cnt)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0), .SYNC_READ(1)) u_sync (
        .clock(clk), .reset(rst), .rReg1(rReg1), .rReg2(rReg2),
        .rData1(s_rd1_o), .rData2(s_rd2_o), .rBusy1(s_b1_o), .rBusy2(s_b2_o),
        .wRegAddrs(wRegAddrs), .wData(wData), .RegWrite(RegWrite),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .issue_stall(s_stall), .pending_count(s_cnt)
    );

    // Reference model: plain register array, one pending flag per register.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_valid = 0;
    logic [31:0] e_srd1, e_srd2;
    bit          e_sb1, e_sb2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && RegWrite && wRegAddrs == a) return wData;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 0;
        return m_pend[a] && !(byp && RegWrite && wRegAddrs == a);
    endfunction

    function automatic bit m_stall();
        return issue_valid && m_pend[issue_addr] && !(RegWrite && wRegAddrs == issue_addr);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
            e_srd1 = '0; e_srd2 = '0; e_sb1 = 0; e_sb2 = 0;
            m_valid = 1;
        end else begin
            bit acc;
            e_srd1 = m_read(rReg1, 0);
            e_srd2 = m_read(rReg2, 0);
            e_sb1  = m_busy(rReg1, 0);
            e_sb2  = m_busy(rReg2, 0);
            acc = issue_valid && !m_stall() && issue_addr != 0;
            if (RegWrite) begin
                if (wRegAddrs != 0) m_regs[wRegAddrs] = wData;
                m_pend[wRegAddrs] = 0;
            end
            if (acc) m_pend[issue_addr] = 1;
        end
    end

    task automatic check_all();
        if (!m_valid) return;
        check("c_rData1", 64'(c_rd1), 64'(m_read(rReg1, 1)));
        check("c_rData2", 64'(c_rd2), 64'(m_read(rReg2, 1)));
        check("c_rBusy1", 64'(c_b1), 64'(m_busy(rReg1, 1)));
        check("c_rBusy2", 64'(c_b2), 64'(m_busy(rReg2, 1)));
        check("c_stall",  64'(c_stall), 64'(m_stall()));
        check("c_count",  64'(c_cnt), 64'(m_count()));
        check("s_rData1", 64'(s_rd1_o), 64'(e_srd1));
        check("s_rData2", 64'(s_rd2_o), 64'(e_srd2));
        check("s_rBusy1", 64'(s_b1_o), 64'(e_sb1));
        check("s_rBusy2", 64'(s_b2_o), 64'(e_sb2));
        check("s_stall",  64'(s_stall), 64'(m_stall()));
        check("s_count",  64'(s_cnt), 64'(m_count()));
    endtask

    task automatic cyc(input bit r, input bit rw, input logic [4:0] wa, input logic [31:0] wd,
                       input bit iv, input logic [4:0] ia, input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        rst = r; RegWrite = rw; wRegAddrs = wa; wData = wd;
        issue_valid = iv; issue_addr = ia; rReg1 = r1; rReg2 = r2;
        #1 check_all();
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Preload, reset, then everything reads back zero.
        cyc(0, 1, 4, 32'hAA, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 9, 0, 0);
        cyc(1, 1, 6, 32'h77, 1, 10, 4, 9);
        cyc(0, 0, 0, 0, 0, 0, 4, 9);
        check("t1_rData1", 64'(c_rd1), 64'h0);
        check("t1_rBusy2", 64'(c_b2), 64'h0);
        check("t1_count",  64'(c_cnt), 64'h0);
        check("t1_s_rData1", 64'(s_rd1_o), 64'h0);

        // Write-through bypass vs. registered no-bypass read.
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
        check("t2_bypass", 64'(c_rd1), 64'hDEADBEEF);
        cyc(0, 0, 0, 0, 0, 0, 5, 0);
        check("t2_s_old", 64'(s_rd1_o), 64'h0);
        cyc(0, 0, 0, 0, 0, 0, 5, 0);
        check("t2_s_new", 64'(s_rd1_o), 64'hDEADBEEF);

        // Register 0 stays zero and never pending.
        cyc(0, 1, 0, 32'h1234, 1, 0, 0, 0);
        check("t3_rData1", 64'(c_rd1), 64'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_rBusy1", 64'(c_b1), 64'h0);
        check("t3_count",  64'(c_cnt), 64'h0);

        // WAW stall on r7, released by a same-cycle retire.
        cyc(0, 0, 0, 0, 1, 7, 0, 7);
        cyc(0, 0, 0, 0, 1, 7, 0, 7);
        check("t4_busy",  64'(c_b2), 64'h1);
        check("t4_count", 64'(c_cnt), 64'h1);
        check("t4_stall", 64'(c_stall), 64'h1);
        cyc(0, 1, 7, 32'h7, 1, 7, 0, 7);
        check("t4_nostall", 64'(c_stall), 64'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 7);
        check("t4_count2", 64'(c_cnt), 64'h1);
        check("t4_busy2",  64'(c_b2), 64'h1);

        // Fill and drain the scoreboard.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 1; a < 32; a++) cyc(0, 0, 0, 0, 1, 5'(a), 5'(a), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_full", 64'(c_cnt), 64'd31);
        for (int a = 1; a < 32; a++) cyc(0, 1, 5'(a), 32'(a * 3), 0, 0, 5'(a), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_empty", 64'(c_cnt), 64'd0);
        cyc(0, 1, 9, 32'h9, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_nounder", 64'(c_cnt), 64'd0);

        // Registered read latency, then reset mid-stream.
        cyc(0, 1, 3, 32'h55, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 3, 0);
        cyc(1, 0, 0, 0, 0, 0, 3, 0);
        check("t6_s_data", 64'(s_rd1_o), 64'h55);
        cyc(0, 0, 0, 0, 0, 0, 3, 0);
        check("t6_s_reset", 64'(s_rd1_o), 64'h0);

        // Randomized traffic on a narrow address window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] hi;
            hi = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
            cyc($urandom_range(0, 99) == 0, 1'($urandom), 5'($urandom_range(0, hi)), $urandom,
                1'($urandom), 5'($urandom_range(0, hi)),
                5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
